odd_counter: RTL and testbench

- Free-running, registered up-counter that produces only odd values: 1, 3, 5, …, 255, then wraps back to 1.
- Used as a simple odd-sequence generator or stimulus source. It has one clock domain and no handshake.
- Output is driven directly from a flop, so it is glitch-free.

---
 rtl/odd_counter_pkg.sv | 14 +
 rtl/odd_step_core.sv | 41 ++++
 rtl/odd_counter.sv | 79 +++++++
 tb/tb_odd_counter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/odd_counter_pkg.sv
// Shared constants and helpers for the odd-sequence counter.
// Latency: n/a (compile-time only).
// Backpressure: n/a (no handshake anywhere in this block).
package odd_counter_pkg;

  localparam int ODD_STEP      = 2;
  localparam int DEFAULT_WIDTH = 8;

  // Used at elaboration to reject even bounds.
  function automatic bit is_odd(input longint value);
    return value[0];
  endfunction

endpackage

// File: rtl/odd_step_core.sv
// Odd-step register: adds ODD_STEP each clock, wraps last -> first.
// Latency: one clock per step; async reset loads first immediately.
// Backpressure: none, free-running with no enable or stall.
module odd_step_core
  import odd_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next;

  // Increment one bit wider than the count; wrap decision uses the
  // pre-increment value, the carry only guards an unreachable state.
  always_comb begin
    w_sum  = {1'b0, r_value} + (WIDTH+1)'(ODD_STEP);
    w_next = w_sum[WIDTH-1:0];
    if (r_value == last || w_sum[WIDTH]) begin
      w_next = first;
    end
  end

  // Count register; reset forces first without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= first;
    end else begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/odd_counter.sv
// Free-running odd counter: FIRST, FIRST+2, ..., LAST, FIRST, ...
// Latency: one clock per step; output straight from a flop.
// Backpressure: none, counts every clock while reset is low.
module odd_counter
  import odd_counter_pkg::*;
#(
  parameter int     WIDTH = DEFAULT_WIDTH,
  parameter longint FIRST = 1,
  parameter longint LAST  = (longint'(1) << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cnt_o
);

  // Bounds must be odd, ordered and representable; refuse to elaborate
  // rather than silently truncate.
  if (WIDTH < 2 || WIDTH > 62) begin : g_bad_width
    $fatal(1, "odd_counter: WIDTH=%0d out of range 2..62", WIDTH);
  end else if (FIRST < 0 || FIRST >= (longint'(1) << WIDTH) || !is_odd(FIRST)) begin : g_bad_first
    $fatal(1, "odd_counter: FIRST=%0d must be odd and below 2**WIDTH", FIRST);
  end else if (LAST >= (longint'(1) << WIDTH) || !is_odd(LAST) || LAST < FIRST) begin : g_bad_last
    $fatal(1, "odd_counter: LAST=%0d must be odd, >= FIRST, below 2**WIDTH", LAST);
  end

  localparam logic [WIDTH-1:0] FIRST_V = WIDTH'(FIRST);
  localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(LAST);

  logic [WIDTH-1:0] w_value;

  odd_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .first (FIRST_V),
    .last  (LAST_V),
    .value (w_value)
  );

  assign cnt_o = w_value;

`ifndef SYNTHESIS
  logic             r_rst_seen;
  logic             r_prev_vld;
  logic [WIDTH-1:0] r_prev;

  // Value is undefined until the first reset; arm the checks only after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_seen <= 1'b1;
    end
  end

  // Remember the value before the last clocked step so each step can be judged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_vld <= 1'b0;
      r_prev     <= FIRST_V;
    end else begin
      r_prev_vld <= 1'b1;
      r_prev     <= w_value;
    end
  end

  a_odd: assert property (@(posedge clk) disable iff (reset)
    r_rst_seen |-> w_value[0]);

  a_range: assert property (@(posedge clk) disable iff (reset)
    r_rst_seen |-> ({1'b0, w_value} >= {1'b0, FIRST_V} &&
                    {1'b0, w_value} <= {1'b0, LAST_V}));

  a_step: assert property (@(posedge clk) disable iff (reset)
    (r_rst_seen && r_prev_vld) |->
      (({1'b0, w_value} == {1'b0, r_prev} + (WIDTH+1)'(ODD_STEP)) ||
       (r_prev == LAST_V && w_value == FIRST_V)));
`endif

endmodule

// File: tb/tb_odd_counter.sv
// Bench for odd_counter: default 8-bit instance plus a 4-bit 5..11 instance.
// Expected values come from a reference model pushed into scoreboards.
// Outputs are sampled 1 ns after the rising edge.
module tb_odd_counter;

  logic       clk;
  logic       reset;
  logic [7:0] cnt8;
  logic [3:0] cnt4;

  int n_chk;
  int n_pass;
  int m8;
  int m4;
  int q8[$];
  int q4[$];

  odd_counter u_dut8 (
    .clk   (clk),
    .reset (reset),
    .cnt_o (cnt8)
  );

  odd_counter #(
    .WIDTH (4),
    .FIRST (5),
    .LAST  (11)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .cnt_o (cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int v, input int first, input int last);
    return (v == last) ? first : v + 2;
  endfunction

  // One rising edge: advance the model, queue its prediction, then compare.
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      m8 = nxt(m8, 1, 255);
      m4 = nxt(m4, 5, 11);
    end
    q8.push_back(m8);
    q4.push_back(m4);
    #1;
    chk("cnt8", int'(cnt8), q8.pop_front());
    chk("cnt4", int'(cnt4), q4.pop_front());
    chk("odd8", int'(cnt8[0]), 1);
  endtask

  initial begin
    int seq8[3];
    int seq4[4];
    int found;
    seq8 = '{3, 5, 7};
    seq4 = '{7, 9, 11, 5};
    n_chk  = 0;
    n_pass = 0;

    // Power-up is undefined; raise reset before the first clock edge.
    reset = 1'b0;
    #1 reset = 1'b1;
    m8 = 1;
    m4 = 5;
    #1;
    chk("rst_async8", int'(cnt8), 1);
    chk("rst_async4", int'(cnt4), 5);

    // Clock edges during reset must not move the count.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_hold", int'(cnt8), 1);
    end

    @(negedge clk);
    reset = 1'b0;

    // Count through two full default periods from release.
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i <= 3) chk("seq8", int'(cnt8), seq8[i-1]);
      if (i <= 4) chk("seq4", int'(cnt4), seq4[i-1]);
      if (i == 8) chk("period4", int'(cnt4), 5);
      if (i == 127) chk("wrap_last", int'(cnt8), 255);
      if (i == 128) chk("wrap_first", int'(cnt8), 1);
      if (i == 255) chk("wrap2_last", int'(cnt8), 255);
      if (i == 256) chk("wrap2_first", int'(cnt8), 1);
    end

    // Run to 101, then pulse reset between clock edges.
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (int'(cnt8) == 101) found = 1;
    end
    chk("reach_101", found, 1);

    #3 reset = 1'b1;
    #1;
    m8 = 1;
    m4 = 5;
    chk("mid_rst8", int'(cnt8), 1);
    chk("mid_rst4", int'(cnt4), 5);
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("resume8", int'(cnt8), 3);
    chk("resume4", int'(cnt4), 7);
    step();
    chk("resume8b", int'(cnt8), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
